// File: rtl/mul_div_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : mul_div_unit_if
// Description : Issue / MTHI-MTLO / result bundle between the pipeline and
//               the multiply-divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface mul_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             dz;

  modport master (
    output start, op, a, b, hi_we, lo_we, wdata,
    input  hi, lo, busy, done, dz
  );

  modport slave (
    input  start, op, a, b, hi_we, lo_we, wdata,
    output hi, lo, busy, done, dz
  );
endinterface
`default_nettype wire

// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : mul_div_unit
// Description : Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO.
//               Shift-add multiply and restoring divide on magnitudes, sign
//               fix-up in a final cycle. Optional macro MDU_FAST_MUL_EN
//               replaces the iterative multiply with a single-cycle one.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          clrn,
  mul_div_unit_if.slave bus
);

  localparam int            CW      = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_IT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q;
  logic [2*WIDTH-1:0]   acc_q;      // mul: product; div: {remainder, quotient}
  logic [WIDTH-1:0]     mag_a_q, mag_b_q, raw_a_q, hi_q, lo_q;
  logic                 div_q, neg_q, sa_q, bz_q, done_q, dz_q;

  // Operand magnitudes at issue; signs only matter for the signed ops.
  logic             w_sa, w_sb;
  logic [WIDTH-1:0] w_mag_a, w_mag_b;
  assign w_sa    = bus.a[WIDTH-1] & ~bus.op[0];
  assign w_sb    = bus.b[WIDTH-1] & ~bus.op[0];
  assign w_mag_a = w_sa ? -bus.a : bus.a;
  assign w_mag_b = w_sb ? -bus.b : bus.b;

  // One iteration: divide consumes dividend bits MSB first.
  logic [2*WIDTH-1:0] w_addend, w_acc_nxt;
  logic [WIDTH:0]     w_rem_sh;
  logic               w_ge;
  logic [WIDTH-1:0]   w_rem_nxt;
  assign w_addend  = {{WIDTH{1'b0}}, mag_a_q} << cnt_q;
  assign w_rem_sh  = {acc_q[2*WIDTH-1:WIDTH], mag_a_q[LAST_IT - cnt_q]};
  assign w_ge      = (w_rem_sh >= {1'b0, mag_b_q});
  assign w_rem_nxt = w_ge ? WIDTH'(w_rem_sh - {1'b0, mag_b_q}) : w_rem_sh[WIDTH-1:0];

  // Next accumulator value for the current iteration.
  always_comb begin
    w_acc_nxt = acc_q;
    if (div_q) begin
      w_acc_nxt = {w_rem_nxt, acc_q[WIDTH-2:0], w_ge};
    end else if (mag_b_q[cnt_q]) begin
      w_acc_nxt = acc_q + w_addend;
    end
  end

  // Sign fix-up of the magnitude results.
  logic [2*WIDTH-1:0] w_prod_mag, w_prod;
  logic [WIDTH-1:0]   w_quo, w_rem;
`ifdef MDU_FAST_MUL_EN
  assign w_prod_mag = {{WIDTH{1'b0}}, mag_a_q} * {{WIDTH{1'b0}}, mag_b_q};
`else
  assign w_prod_mag = acc_q;
`endif
  assign w_prod = neg_q ? -w_prod_mag : w_prod_mag;
  assign w_quo  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign w_rem  = sa_q  ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  // State register.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
`ifdef MDU_FAST_MUL_EN
          state_d = bus.op[1] ? S_CALC : S_FIX;
`else
          state_d = S_CALC;
`endif
        end
      end
      S_CALC:  if (cnt_q == LAST_IT) state_d = S_FIX;
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath, HI/LO and result flags.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      cnt_q   <= '0;
      acc_q   <= '0;
      mag_a_q <= '0;
      mag_b_q <= '0;
      raw_a_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      sa_q    <= 1'b0;
      bz_q    <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      dz_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            div_q   <= bus.op[1];
            sa_q    <= w_sa;
            neg_q   <= w_sa ^ w_sb;
            mag_a_q <= w_mag_a;
            mag_b_q <= w_mag_b;
            raw_a_q <= bus.a;
            bz_q    <= (bus.b == '0);
            cnt_q   <= '0;
            acc_q   <= '0;
          end else begin
            if (bus.hi_we) hi_q <= bus.wdata;
            if (bus.lo_we) lo_q <= bus.wdata;
          end
        end
        S_CALC: begin
          acc_q <= w_acc_nxt;
          cnt_q <= cnt_q + CW'(1);
        end
        S_FIX: begin
          done_q <= 1'b1;
          if (div_q && bz_q) begin
            hi_q <= raw_a_q;
            lo_q <= '1;
            dz_q <= 1'b1;
          end else if (div_q) begin
            hi_q <= w_rem;
            lo_q <= w_quo;
          end else begin
            hi_q <= w_prod[2*WIDTH-1:WIDTH];
            lo_q <= w_prod[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
  assign bus.busy = (state_q != S_IDLE);
  assign bus.done = done_q;
  assign bus.dz   = dz_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_div_unit
// Description : Self-checking bench for mul_div_unit: directed corner cases,
//               randomized operations against an arithmetic reference model,
//               MTHI/MTLO and mid-operation reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_div_unit;

  logic clk  = 1'b0;
  logic clrn = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [31:0] m_hi = 32'h0;
  logic [31:0] m_lo = 32'h0;

  mul_div_unit_if #(.WIDTH(32)) bus ();

  mul_div_unit #(.WIDTH(32)) dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference result {dz, hi, lo} from plain integer arithmetic.
  function automatic logic [64:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, p, q, rm;
    longint unsigned ua, ub, up, uq, urm;
    logic [64:0]     r;
    sa = $signed(a);
    sb = $signed(b);
    ua = a;
    ub = b;
    r  = '0;
    case (op)
      2'b00: begin p = sa * sb; r = {1'b0, p}; end
      2'b01: begin up = ua * ub; r = {1'b0, up}; end
      2'b10: begin
        if (b == 32'h0) r = {1'b1, a, 32'hFFFF_FFFF};
        else begin q = sa / sb; rm = sa % sb; r = {1'b0, rm[31:0], q[31:0]}; end
      end
      default: begin
        if (b == 32'h0) r = {1'b1, a, 32'hFFFF_FFFF};
        else begin uq = ua / ub; urm = ua % ub; r = {1'b0, urm[31:0], uq[31:0]}; end
      end
    endcase
    return r;
  endfunction

  // Issue one operation and check latency, busy window, HI/LO hold and result.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit with_we, input bit inject);
    logic [64:0] exp;
    int          lat, busy_n, exp_lat;
    bit          held;
    exp = model(op, a, b);
`ifdef MDU_FAST_MUL_EN
    exp_lat = op[1] ? 33 : 1;
`else
    exp_lat = 33;
`endif
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    if (with_we) begin
      bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = $urandom;
    end
    @(posedge clk); #1;
    bus.start = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    lat = 0; busy_n = 0; held = 1'b1;
    while (!bus.done && lat < 40) begin
      if (bus.busy) busy_n++;
      if (bus.hi !== m_hi || bus.lo !== m_lo) held = 1'b0;
      if (inject && lat == 5) begin
        bus.start = 1'b1; bus.op = 2'b01; bus.a = 32'd3; bus.b = 32'd3;
        bus.hi_we = 1'b1; bus.wdata = 32'h1234;
      end
      if (inject && lat == 6) begin
        bus.start = 1'b0; bus.hi_we = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, exp_lat);
    chk("busy_cycles", busy_n, exp_lat);
    chk("hilo_hold", held, 1);
    chk("busy_at_done", bus.busy, 0);
    chk("hi", bus.hi, exp[63:32]);
    chk("lo", bus.lo, exp[31:0]);
    chk("dz", bus.dz, exp[64]);
    m_hi = exp[63:32];
    m_lo = exp[31:0];
    @(posedge clk); #1;
    chk("done_pulse", bus.done, 0);
    chk("dz_pulse", bus.dz, 0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    bit          seen;
    bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
    bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_hi", bus.hi, 0);
    chk("rst_lo", bus.lo, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_dz", bus.dz, 0);
    @(negedge clk) clrn = 1'b1;

    // MTHI + MTLO together, then MTHI alone.
    @(negedge clk);
    bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'hCAFE_0001;
    @(posedge clk); #1;
    bus.lo_we = 1'b0; bus.wdata = 32'h5555_AAAA;
    chk("mt_both_hi", bus.hi, 32'hCAFE_0001);
    chk("mt_both_lo", bus.lo, 32'hCAFE_0001);
    @(posedge clk); #1;
    bus.hi_we = 1'b0;
    chk("mthi_hi", bus.hi, 32'h5555_AAAA);
    chk("mthi_lo", bus.lo, 32'hCAFE_0001);
    m_hi = 32'h5555_AAAA; m_lo = 32'hCAFE_0001;

    // Directed corner cases.
    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    do_op(2'b00, 32'hFFFF_FFFD, 32'd5,         1'b1, 1'b0);
    do_op(2'b10, 32'hFFFF_FFF9, 32'd2,         1'b0, 1'b0);
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    do_op(2'b11, 32'd100,       32'd0,         1'b0, 1'b0);
    do_op(2'b10, 32'hFFFF_FF00, 32'd0,         1'b0, 1'b0);
    do_op(2'b11, 32'd100,       32'd7,         1'b0, 1'b1);
    do_op(2'b10, 32'd7,         32'hFFFF_FFFE, 1'b0, 1'b0);

    // Randomized operations.
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'h0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = $urandom_range(1, 20);
        3: ra = $urandom_range(0, 1000);
        default: ;
      endcase
      do_op(2'($urandom_range(0, 3)), ra, rb, 1'($urandom_range(0, 1)), 1'b0);
    end

    // Reset in the middle of an operation.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b01; bus.a = 32'h1234_5678; bus.b = 32'h9ABC_DEF0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #2 clrn = 1'b0;
    #1;
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_hi", bus.hi, 0);
    chk("midrst_lo", bus.lo, 0);
    @(negedge clk) clrn = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) seen = 1'b1;
    end
    chk("midrst_no_done", seen, 0);
    @(negedge clk);
    bus.lo_we = 1'b1; bus.wdata = 32'h0000_ABCD;
    @(posedge clk); #1;
    bus.lo_we = 1'b0;
    chk("mtlo_after_rst_lo", bus.lo, 32'h0000_ABCD);
    chk("mtlo_after_rst_hi", bus.hi, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mul_div_unit.md
# mul_div_unit

Multi-cycle integer multiply/divide unit with architectural HI/LO registers, sitting beside the EXE stage of the 5-stage pipeline. It accepts MULT/MULTU/DIV/DIVU operands from the ID/EXE register (`eqa`, `eqb`) and executes them iteratively. It produces HI/LO for MFHI/MFLO, and drives `busy` into the control unit so that `wpcir` stalls dependent HI/LO reads and new multiply/divide issues.

## Interface
Parameters:
- `WIDTH`, 32, operand and HI/LO width. Only 32 is verified.

Ports:
- `clk`  in  1  pipeline clock; rising-edge active.
- `clrn`  in  1  asynchronous active-low reset.
- `start`  in  1  issue request; sampled on the rising edge.
- `op`  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `a`  in  32  rs operand (multiplicand / dividend).
- `b`  in  32  rt operand (multiplier / divisor).
- `hi_we`  in  1  MTHI write enable.
- `lo_we`  in  1  MTLO write enable.
- `wdata`  in  32  MTHI/MTLO data.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.
- `busy`  out  1  operation in flight.
- `done`  out  1  one-cycle pulse when HI/LO are updated by an operation.
- `dz`  out  1  divide-by-zero flag, valid with `done`.

## Operation
- FSM states: IDLE, CALC, FIX.
- IDLE, `start`=1:
  - latch `op`, `|a|`, `|b|`, and the signs; signs count only for op 00/10.
  - clear the 5-bit counter and the 64-bit accumulator.
  - go to CALC.
- CALC performs one iteration per cycle; after iteration 31 it goes to FIX.
  - Multiply: shift-add on magnitudes, 64-bit product.
  - Divide: restoring division, one quotient bit per cycle, 32-bit remainder.
- FIX: apply sign correction, write HI/LO, assert `done`, return to IDLE.
- Sign rules:
  - Product negated if sign(a)^sign(b).
  - Quotient negated if sign(a)^sign(b).
  - Remainder takes the sign of `a`.
- Divide by zero (`b`=0, DIV or DIVU):
  - latency unchanged.
  - result forced to `lo`=0xFFFFFFFF, `hi`=`a` (raw), `dz`=1 with `done`.
- 0x80000000 / -1 (DIV): `lo`=0x80000000, `hi`=0. No trap.
- `start` while `busy`=1 is ignored; the in-flight operation is unaffected.
- `hi_we` / `lo_we`:
  - write `wdata` at the edge when in IDLE and `start`=0.
  - dropped when `busy`=1 or when `start`=1 on the same edge.
  - `hi_we` and `lo_we` may both be high; both registers are then written.
- `hi`/`lo` hold their previous values throughout CALC. Intermediate results are never visible.

## Timing
- Reset (`clrn`=0, asynchronous, any state including mid-operation):
  - state IDLE, `hi`=`lo`=0, `busy`=0, `done`=0, `dz`=0, counter=0.
- `start` sampled at edge N. Then:
  - `busy`=1 after edge N through edge N+33.
  - edges N+1..N+32: iterations 0..31.
  - edge N+33: FIX writes `hi`/`lo`. `done`=1 and `busy`=0 during the cycle after N+33.
  - total latency: 33 edges.
- A new `start` may be sampled at edge N+33+1, i.e. the cycle `done` is high. Back-to-back throughput: one operation per 34 cycles.
- `done` and `dz` are registered, single-cycle, and low otherwise.
- MTHI/MTLO: value visible on `hi`/`lo` in the cycle after the write edge.

## Configuration
- `MDU_FAST_MUL_EN` defined:
  - MULT/MULTU use a single-cycle combinational 32x32 multiplier and skip CALC: IDLE → FIX.
  - `start` at edge N → `hi`/`lo` written at edge N+1, `done` in the cycle after N+1, `busy` high for one cycle.
  - Divides are unchanged.
- `MDU_FAST_MUL_EN` undefined: all operations are iterative with 33-edge latency. No multiplier is inferred.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001. `done` at edge N+33, or N+1 with `MDU_FAST_MUL_EN`.
- MULT -3 × 5 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1. `busy` is high for exactly 33 cycles.
- DIV -7 / 2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- DIVU 100 / 0 → `lo`=0xFFFFFFFF, `hi`=0x00000064, `dz`=1 with `done`.
- DIVU 100/7 started. Then, while busy: MULTU 3×3 `start` and `hi_we` with `wdata`=0x1234 → both ignored; final `lo`=14, `hi`=2.
- MULTU started, `clrn` pulsed low at iteration 10 → immediately `busy`=0, `hi`=`lo`=0, no `done`. A subsequent MTLO 0xABCD → `lo`=0x0000ABCD the next cycle.
